// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared types and defaults for mac_scheduler
//
// Purpose: FSM state type, datapath size defaults and channel indices
//          used by mac_scheduler and its round-robin arbiter.
// Ports:   none (package).
package mac_sched_pkg;

    localparam int P_TAPS   = 32;
    localparam int P_ADDR_W = 5;
    localparam int P_ACC_W  = 21;

    localparam logic CH_I = 1'b0;
    localparam logic CH_Q = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// rtl/mac_scheduler_rr_arbiter.sv - two-requester round-robin arbiter
//
// Purpose: picks one of two eligible requesters; the channel served last
//          loses a tie. The pointer only moves when a pass is completed.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_req        : per-channel request level
//   i_mask       : channels excluded this cycle
//   i_update     : a pass for i_upd_ch has just completed
//   i_upd_ch     : channel whose pass completed
//   o_grant      : winning channel index (combinational)
//   o_valid      : at least one eligible requester (combinational)
module rr_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_update,
    input  logic       i_upd_ch,
    output logic       o_grant,
    output logic       o_valid
);
    import mac_sched_pkg::*;

    logic       r_last;
    logic [1:0] w_elig;

    assign w_elig  = i_req & ~i_mask;
    assign o_valid = |w_elig;
    // Tie: the channel that was not served last wins; otherwise the lone requester.
    assign o_grant = (&w_elig) ? ~r_last : w_elig[1];

    // Starting with Q as "last served" gives I priority after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= CH_Q;
        end else if (i_update) begin
            r_last <= i_upd_ch;
        end
    end

endmodule

// File: rtl/mac_scheduler.sv
// rtl/mac_scheduler.sv - time-shares one FIR MAC datapath between I and Q channels
//
// Purpose: arbitrates I/Q pass requests, walks the taps on the delay line and
//          coefficient ROM, sequences the MAC, captures the accumulator and
//          hands the result out over a valid/ready handshake with an ack pulse.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   req[1:0]             : per-channel request level, held until ack
//   ack[1:0]             : one-cycle pulse on the channel whose result was taken
//   busy                 : high outside IDLE
//   grant_ch             : channel owning the datapath (delay-line mux select)
//   line_addr, rom_addr  : tap index into delay line / coefficient ROM
//   mac_en, mac_init     : MAC accumulate enable / load-first-product
//   mac_data             : registered MAC accumulator
//   result_data/_ch      : captured filter output and its channel
//   result_valid/_ready  : output handshake
module mac_scheduler #(
    parameter int P_TAPS   = mac_sched_pkg::P_TAPS,
    parameter int P_ADDR_W = mac_sched_pkg::P_ADDR_W,
    parameter int P_ACC_W  = mac_sched_pkg::P_ACC_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    output logic [1:0]          ack,
    output logic                busy,
    output logic                grant_ch,
    output logic [P_ADDR_W-1:0] line_addr,
    output logic [P_ADDR_W-1:0] rom_addr,
    output logic                mac_en,
    output logic                mac_init,
    input  logic [P_ACC_W-1:0]  mac_data,
    output logic [P_ACC_W-1:0]  result_data,
    output logic                result_ch,
    output logic                result_valid,
    input  logic                result_ready
);
    import mac_sched_pkg::*;

    state_t              r_state;
    logic [P_ADDR_W-1:0] r_tap;
    logic                w_grant;
    logic                w_grant_valid;
    logic                w_served;

    assign w_served = (r_state == OUT) && result_ready;

    // A channel acked last cycle is masked so a late req drop cannot regrant it.
    rr_arbiter u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (req),
        .i_mask   (ack),
        .i_update (w_served),
        .i_upd_ch (grant_ch),
        .o_grant  (w_grant),
        .o_valid  (w_grant_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_tap        <= '0;
            ack          <= '0;
            busy         <= 1'b0;
            grant_ch     <= 1'b0;
            line_addr    <= '0;
            rom_addr     <= '0;
            mac_en       <= 1'b0;
            mac_init     <= 1'b0;
            result_data  <= '0;
            result_ch    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        grant_ch  <= w_grant;
                        busy      <= 1'b1;
                        r_tap     <= '0;
                        line_addr <= '0;
                        rom_addr  <= '0;
                        mac_en    <= 1'b1;
                        mac_init  <= 1'b1;
                        r_state   <= MAC;
                    end
                end
                MAC: begin
                    mac_init <= 1'b0;
                    if (r_tap == P_ADDR_W'(P_TAPS - 1)) begin
                        // Addresses keep the last tap; only the enable drops.
                        mac_en  <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_tap     <= r_tap + 1'b1;
                        line_addr <= r_tap + 1'b1;
                        rom_addr  <= r_tap + 1'b1;
                    end
                end
                DRAIN: begin
                    // The MAC registers its last product here, so mac_data is complete.
                    result_data  <= mac_data;
                    result_ch    <= grant_ch;
                    result_valid <= 1'b1;
                    r_state      <= OUT;
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid  <= 1'b0;
                        ack[grant_ch] <= 1'b1;
                        busy          <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
